// File: rtl/rv32_pkg.sv
// Shared RV32 types for the data-memory path: data word, 13-bit word address,
// and the requester vector used by the data-memory arbiter.
package rv32_pkg;

   localparam int RV32_XLEN    = 32;
   localparam int RV32_DMEM_AW = 13;

   typedef logic [RV32_XLEN-1:0]    rv32_data_t;
   typedef logic [RV32_DMEM_AW-1:0] rv32_dmem_addr_t;

   localparam int RV32_DMEM_NUM_REQ = 4;

   typedef logic [RV32_DMEM_NUM_REQ-1:0] rv32_dmem_req_vec_t;

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (with wrap-around); the pointer moves just past the winner.
module rv32_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic [N-1:0]  rot;
   logic [N-1:0]  rot_gnt;

   // Rotate requests so the pointer sits at bit 0, isolate the lowest set bit,
   // then rotate the one-hot result back into requester order.
   always_comb begin
      rot      = N'({req, req} >> ptr);
      rot_gnt  = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
      gnt      = N'(({rot_gnt, rot_gnt} << ptr) >> N);
      ptr_next = ptr;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            ptr_next = (i == N-1) ? '0 : PW'(i + 1);
         end
      end
   end

   // Pointer register; holds when nothing is granted.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/rv32_dmem_arbiter.sv
// Data-memory arbiter: shares the single read and single write port of
// rv32_data_memory between NUM_REQ requesters using independent round-robin
// arbiters, and routes the 1-cycle-late read data back to the issuer.
// Optional macro RV32_DMEM_ARB_FWD_EN forwards same-cycle same-address write
// data to the read; without it the read sees the BRAM's old (read-first) value.
module rv32_dmem_arbiter
   import rv32_pkg::*;
#(
   parameter int NUM_REQ = RV32_DMEM_NUM_REQ
) (
   input  logic                           clock,
   input  logic                           rst_n,
   input  logic            [NUM_REQ-1:0]  req_i,
   input  logic            [NUM_REQ-1:0]  we_i,
   input  rv32_dmem_addr_t [NUM_REQ-1:0]  addr_i,
   input  rv32_data_t      [NUM_REQ-1:0]  wdata_i,
   output logic            [NUM_REQ-1:0]  gnt_o,
   output logic            [NUM_REQ-1:0]  rvalid_o,
   output rv32_data_t                     rdata_o,
   output rv32_data_t                     mem_data_o,
   output rv32_dmem_addr_t                mem_wraddress_o,
   output logic                           mem_wren_o,
   output rv32_dmem_addr_t                mem_rdaddress_o,
   input  rv32_data_t                     mem_q_i
);

   logic [NUM_REQ-1:0] rd_req;
   logic [NUM_REQ-1:0] wr_req;
   logic [NUM_REQ-1:0] rd_gnt;
   logic [NUM_REQ-1:0] wr_gnt;
   logic [NUM_REQ-1:0] rd_pend;

   // Split requests into read and write classes; held in reset nothing is granted.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_class
         assign rd_req[gi] = req_i[gi] & ~we_i[gi] & rst_n;
         assign wr_req[gi] = req_i[gi] &  we_i[gi] & rst_n;
      end
   endgenerate

   rv32_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .clock (clock),
      .rst_n (rst_n),
      .req   (rd_req),
      .gnt   (rd_gnt)
   );

   rv32_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .clock (clock),
      .rst_n (rst_n),
      .req   (wr_req),
      .gnt   (wr_gnt)
   );

   assign gnt_o      = rd_gnt | wr_gnt;
   assign mem_wren_o = |wr_gnt;

   // One-hot muxes steering the winners' address/data onto the memory ports.
   always_comb begin
      mem_wraddress_o = '0;
      mem_data_o      = '0;
      mem_rdaddress_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_gnt[i]) begin
            mem_wraddress_o = addr_i[i];
            mem_data_o      = wdata_i[i];
         end
         if (rd_gnt[i]) begin
            mem_rdaddress_o = addr_i[i];
         end
      end
   end

   // Remember who issued the read so the response lands on the right requester.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend <= '0;
      end else begin
         rd_pend <= rd_gnt;
      end
   end

   assign rvalid_o = rd_pend;

`ifdef RV32_DMEM_ARB_FWD_EN
   logic       fwd_hit;
   rv32_data_t fwd_data;

   // Flag a same-cycle read/write collision on the same word.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         fwd_hit <= 1'b0;
      end else begin
         fwd_hit <= (|rd_gnt) && (|wr_gnt) && (mem_rdaddress_o == mem_wraddress_o);
      end
   end

   // Capture the colliding write data; only consumed when fwd_hit is set.
   always_ff @(posedge clock) begin
      fwd_data <= mem_data_o;
   end

   assign rdata_o = fwd_hit ? fwd_data : mem_q_i;
`else
   assign rdata_o = mem_q_i;
`endif

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// Self-checking bench for rv32_dmem_arbiter with a behavioural read-first BRAM.
module tb_rv32_dmem_arbiter;
   import rv32_pkg::*;

   localparam int N = 4;

   typedef struct {
      logic [N-1:0] id;
      rv32_data_t   data;
   } exp_t;

   logic                    clock = 1'b0;
   logic                    rst_n = 1'b0;
   logic            [N-1:0] req;
   logic            [N-1:0] we;
   rv32_dmem_addr_t [N-1:0] addr;
   rv32_data_t      [N-1:0] wdata;
   logic            [N-1:0] gnt;
   logic            [N-1:0] rvalid;
   rv32_data_t              rdata;
   rv32_data_t              mem_data;
   rv32_dmem_addr_t         mem_wraddress;
   logic                    mem_wren;
   rv32_dmem_addr_t         mem_rdaddress;
   rv32_data_t              mem_q;

   rv32_data_t bram    [0:8191];
   rv32_data_t ref_mem [0:8191];
   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   rv32_dmem_arbiter #(.NUM_REQ(N)) dut (
      .clock           (clock),
      .rst_n           (rst_n),
      .req_i           (req),
      .we_i            (we),
      .addr_i          (addr),
      .wdata_i         (wdata),
      .gnt_o           (gnt),
      .rvalid_o        (rvalid),
      .rdata_o         (rdata),
      .mem_data_o      (mem_data),
      .mem_wraddress_o (mem_wraddress),
      .mem_wren_o      (mem_wren),
      .mem_rdaddress_o (mem_rdaddress),
      .mem_q_i         (mem_q)
   );

   always #5 clock = ~clock;

   // Read-first BRAM model with registered read.
   initial begin
      for (int i = 0; i < 8192; i++) bram[i] = 32'h5A000000 | i;
      bram[13'h1FF] = 32'h0;
      forever begin
         @(posedge clock);
         if (mem_wren) bram[mem_wraddress] <= mem_data;
         mem_q <= bram[mem_rdaddress];
      end
   end

   // Update the reference memory and queue the expected read response for one grant cycle.
   task automatic model_cycle(input logic [N-1:0] eg);
      int   rd_i = -1;
      int   wr_i = -1;
      exp_t e;
      for (int i = 0; i < N; i++) begin
         if (eg[i]) begin
            if (we[i]) wr_i = i;
            else       rd_i = i;
         end
      end
      if (rd_i >= 0) begin
         e.id       = '0;
         e.id[rd_i] = 1'b1;
         e.data     = ref_mem[addr[rd_i]];
`ifdef RV32_DMEM_ARB_FWD_EN
         if (wr_i >= 0 && addr[wr_i] == addr[rd_i]) e.data = wdata[wr_i];
`endif
         sb.push_back(e);
      end
      if (wr_i >= 0) ref_mem[addr[wr_i]] = wdata[wr_i];
   endtask

   task automatic do_reset();
      req   = '0;
      we    = '0;
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '1;
      we    = 4'b0011;
      @(posedge clock);
      @(negedge clock);
      n_checks++;
      if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_checks++;
      if (rvalid !== '0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
      n_checks++;
      if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", mem_wren); end
      do_reset();
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      logic [N-1:0] eg;
      exp_t         e;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req = '0; we = '0;
         if (c < 2) begin
            req      = 4'b0100;
            we       = (c == 0) ? 4'b0100 : 4'b0000;
            addr[2]  = 13'h010;
            wdata[2] = 32'hDEADBEEF;
         end
         eg = req;
         @(negedge clock);
         n_checks++;
         if (gnt !== eg) begin n_fail++; $display("FAIL wr_rd_gnt c%0d: got %b expected %b", c, gnt, eg); end
         n_checks++;
         if (mem_wren !== |(eg & we)) begin n_fail++; $display("FAIL wr_rd_wren c%0d: got %b expected %b", c, mem_wren, |(eg & we)); end
         model_cycle(eg);
         @(posedge clock); #1;
         n_checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rvalid !== e.id || rdata !== e.data) begin
               n_fail++; $display("FAIL wr_rd_resp c%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, e.id, e.data);
            end
         end else if (rvalid !== '0) begin
            n_fail++; $display("FAIL wr_rd_resp c%0d: got rvalid=%b expected 0000", c, rvalid);
         end
         $display("write_read cycle %0d gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] eg;
      exp_t         e;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         req = (c < 8) ? 4'b1111 : 4'b0000;
         we  = '0;
         for (int i = 0; i < N; i++) addr[i] = 13'h100 + 13'(i);
         eg = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
         @(negedge clock);
         n_checks++;
         if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, eg); end
         model_cycle(eg);
         @(posedge clock); #1;
         n_checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rvalid !== e.id || rdata !== e.data) begin
               n_fail++; $display("FAIL rr_resp c%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, e.id, e.data);
            end
         end else if (rvalid !== '0) begin
            n_fail++; $display("FAIL rr_resp c%0d: got rvalid=%b expected 0000", c, rvalid);
         end
         $display("round_robin cycle %0d gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      end
   endtask

   task automatic test_rw_parallel();
      logic [N-1:0] eg;
      exp_t         e;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req = '0; we = '0; eg = '0;
         if (c == 0) begin
            req = 4'b0011; we = 4'b0001;
            addr[0] = 13'h020; wdata[0] = 32'hCAFEF00D;
            addr[1] = 13'h030;
            eg = 4'b0011;
         end else if (c == 1) begin
            req = 4'b0010; addr[1] = 13'h020;
            eg = 4'b0010;
         end
         @(negedge clock);
         n_checks++;
         if (gnt !== eg) begin n_fail++; $display("FAIL rw_gnt c%0d: got %b expected %b", c, gnt, eg); end
         n_checks++;
         if (mem_wren !== |(eg & we)) begin n_fail++; $display("FAIL rw_wren c%0d: got %b expected %b", c, mem_wren, |(eg & we)); end
         model_cycle(eg);
         @(posedge clock); #1;
         n_checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rvalid !== e.id || rdata !== e.data) begin
               n_fail++; $display("FAIL rw_resp c%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, e.id, e.data);
            end
         end else if (rvalid !== '0) begin
            n_fail++; $display("FAIL rw_resp c%0d: got rvalid=%b expected 0000", c, rvalid);
         end
         $display("rw_parallel cycle %0d gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      end
   endtask

   task automatic test_same_addr();
      logic [N-1:0] eg;
      exp_t         e;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req = '0; we = '0; eg = '0;
         if (c == 0) begin
            req = 4'b1001; we = 4'b0001;
            addr[0] = 13'h1FF; wdata[0] = 32'h12345678;
            addr[3] = 13'h1FF;
            eg = 4'b1001;
         end else if (c == 1) begin
            req = 4'b1000;
            eg = 4'b1000;
         end
         @(negedge clock);
         n_checks++;
         if (gnt !== eg) begin n_fail++; $display("FAIL same_gnt c%0d: got %b expected %b", c, gnt, eg); end
         model_cycle(eg);
         @(posedge clock); #1;
         n_checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rvalid !== e.id || rdata !== e.data) begin
               n_fail++; $display("FAIL same_resp c%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, e.id, e.data);
            end
         end else if (rvalid !== '0) begin
            n_fail++; $display("FAIL same_resp c%0d: got rvalid=%b expected 0000", c, rvalid);
         end
         $display("same_addr cycle %0d gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] eg;
      exp_t         e;
      do_reset();
      // Cycle 0: move read pointer to 2 and write pointer to 1.
      req = 4'b0011; we = 4'b0001;
      addr[0] = 13'h050; wdata[0] = 32'h0BADF00D; addr[1] = 13'h040;
      eg = 4'b0011;
      @(negedge clock);
      n_checks++;
      if (gnt !== eg) begin n_fail++; $display("FAIL rmid_gnt0: got %b expected %b", gnt, eg); end
      model_cycle(eg);
      @(posedge clock); #1;
      n_checks++;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (rvalid !== e.id || rdata !== e.data) begin
            n_fail++; $display("FAIL rmid_resp0: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", rvalid, rdata, e.id, e.data);
         end
      end
      $display("reset_mid cycle 0 gnt=%b rvalid=%b rdata=%h", gnt, rvalid, rdata);
      // Cycle 1: requester 1 granted a read, then reset hits before the response.
      req = 4'b0010; we = '0; addr[1] = 13'h041;
      @(negedge clock);
      n_checks++;
      if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rmid_gnt1: got %b expected 0010", gnt); end
      rst_n = 1'b0;
      req   = '0;
      #1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rvalid !== '0) begin n_fail++; $display("FAIL rmid_rvalid k%0d: got %b expected 0000", k, rvalid); end
         $display("reset_mid hold %0d rvalid=%b", k, rvalid);
         if (k < 3) begin @(posedge clock); #1; end
      end
      @(negedge clock);
      rst_n = 1'b1;
      @(posedge clock); #1;
      n_checks++;
      if (rvalid !== '0) begin n_fail++; $display("FAIL rmid_rvalid_rel: got %b expected 0000", rvalid); end
      // Both pointers back at 0: reads {1,3} pick 1, writes {0,2} pick 0.
      for (int c = 0; c < 2; c++) begin
         req = (c == 0) ? 4'b1111 : 4'b0000;
         we  = 4'b0101;
         for (int i = 0; i < N; i++) begin
            addr[i]  = 13'h060 + 13'(i);
            wdata[i] = 32'h600D0000 | i;
         end
         eg = (c == 0) ? 4'b0011 : 4'b0000;
         @(negedge clock);
         n_checks++;
         if (gnt !== eg) begin n_fail++; $display("FAIL rmid_ptr_gnt c%0d: got %b expected %b", c, gnt, eg); end
         model_cycle(eg);
         @(posedge clock); #1;
         n_checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rvalid !== e.id || rdata !== e.data) begin
               n_fail++; $display("FAIL rmid_ptr_resp c%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, e.id, e.data);
            end
         end else if (rvalid !== '0) begin
            n_fail++; $display("FAIL rmid_ptr_resp c%0d: got rvalid=%b expected 0000", c, rvalid);
         end
         $display("reset_mid post cycle %0d gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      end
   endtask

   task automatic test_starvation();
      logic [N-1:0] eg;
      logic [N-1:0] req_tab [6];
      logic [N-1:0] eg_tab  [6];
      exp_t         e;
      req_tab = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
      eg_tab  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0000};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         req = req_tab[c]; we = '0;
         addr[1] = 13'h070 + 13'(c);
         addr[3] = 13'h073;
         eg = eg_tab[c];
         @(negedge clock);
         n_checks++;
         if (gnt !== eg) begin n_fail++; $display("FAIL starve_gnt c%0d: got %b expected %b", c, gnt, eg); end
         model_cycle(eg);
         @(posedge clock); #1;
         n_checks++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rvalid !== e.id || rdata !== e.data) begin
               n_fail++; $display("FAIL starve_resp c%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h", c, rvalid, rdata, e.id, e.data);
            end
         end else if (rvalid !== '0) begin
            n_fail++; $display("FAIL starve_resp c%0d: got rvalid=%b expected 0000", c, rvalid);
         end
         $display("starvation cycle %0d gnt=%b rvalid=%b rdata=%h", c, gnt, rvalid, rdata);
      end
   endtask

   initial begin
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      for (int i = 0; i < 8192; i++) ref_mem[i] = 32'h5A000000 | i;
      ref_mem[13'h1FF] = 32'h0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_rw_parallel();
      test_same_addr();
      test_reset_mid();
      test_starvation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rv32_dmem_arbiter.md
# rv32_dmem_arbiter

Shares the single write port and single read port of `rv32_data_memory` between `NUM_REQ` requesters (hart load/store unit, host loader, debug port). Reads and writes are arbitrated independently with two round-robin arbiters, so one read and one write can be granted in the same cycle. The block tracks the 1-cycle BRAM read latency and returns read data to the requester that issued the read. It sits between the requesters and `rv32_data_memory`, and drives that memory's ports directly.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..8.
- `clock` in, 1: system clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `req_i` in, `[NUM_REQ]`: request valid per requester.
- `we_i` in, `[NUM_REQ]`: 1 = write, 0 = read.
- `addr_i` in, `[NUM_REQ]` x `rv32_dmem_addr_t`: word address (13 b).
- `wdata_i` in, `[NUM_REQ]` x `rv32_data_t`: write data.
- `gnt_o` out, `[NUM_REQ]`: request accepted this cycle.
- `rvalid_o` out, `[NUM_REQ]`: read data valid for that requester.
- `rdata_o` out, `rv32_data_t`: read data, shared by all requesters; qualified by `rvalid_o`.
- `mem_data_o`, `mem_wraddress_o`, `mem_wren_o`, `mem_rdaddress_o` out: drive `rv32_data_memory` `data`, `wraddress`, `wren` and `rdaddress`.
- `mem_q_i` in, `rv32_data_t`: from `rv32_data_memory` `q`.

## Operation
- Two request classes:
  - Read: `req_i & ~we_i`.
  - Write: `req_i & we_i`.
- Each class has its own round-robin arbiter. A requester presents only one transaction per cycle.
- Grant:
  - The winner is the first requesting index at or after that class's pointer, searching upward with wrap-around.
  - `gnt_o` is combinational from `req_i` and the pointers, in the same cycle.
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt_o`.
- Pointer update: on a grant to index k, that class's pointer becomes (k+1) mod `NUM_REQ` at the next edge. With no grant, the pointer holds.
- Write grant:
  - `mem_wren_o`=1.
  - `mem_wraddress_o` and `mem_data_o` come from the winner.
  - When there is no write grant, `mem_wren_o`=0 and address/data are don't-care.
- Read grant:
  - `mem_rdaddress_o` is the winner's address.
  - The winner's one-hot id is registered as `rd_pend`.
  - The next cycle, `rvalid_o` = `rd_pend` and `rdata_o` = `mem_q_i`.
- Back-to-back reads are allowed every cycle, so read throughput is 1 per cycle.
- No queuing: ungranted requests are simply re-evaluated the next cycle.
- Fairness: with all `NUM_REQ` requesting continuously, each requester is granted exactly once per `NUM_REQ` cycles per class.

## Timing
- Reset state (async assert; deassert synchronous to `clock`):
  - Both pointers = 0, `rd_pend` = 0.
  - `rvalid_o` = 0, `mem_wren_o` = 0, `gnt_o` = 0.
  - `rdata_o` is not reset; it is qualified by `rvalid_o`.
- Latency:
  - Grant: 0 cycles, combinational.
  - Write: memory updated at the edge ending the grant cycle.
  - Read: `rvalid_o` is high exactly 1 cycle after the grant cycle.
- Same requester reads then writes on consecutive cycles: legal, no hazard.
- Reset asserted mid-operation: pending read responses are dropped (`rvalid_o` never pulses). Requesters must reissue.
- Same-cycle read and write to the same address: see Configuration. Read-after-write on a later cycle always returns the new data.

## Configuration
- Macro: `RV32_DMEM_ARB_FWD_EN`.
- Defined:
  - If the read and write are granted in the same cycle with equal addresses, the write data is registered.
  - The next cycle, `rdata_o` returns that registered write data instead of `mem_q_i`, so the read sees the new value.
- Undefined:
  - No compare and no forwarding register; `rdata_o` = `mem_q_i` always.
  - The same-address same-cycle read returns BRAM read-first data (the old value).

## Structure
- `rv32_pkg` additions:
  - `localparam RV32_DMEM_NUM_REQ = 4`.
  - `typedef logic [RV32_DMEM_NUM_REQ-1:0] rv32_dmem_req_vec_t`.
  - Reuses the existing `rv32_data_t` and `rv32_dmem_addr_t`.
- Sub-module `rv32_rr_arbiter`, parameterized by N: request vector in, one-hot grant out, internal pointer with async active-low reset. It is instantiated twice (read, write).
- The top level holds `rd_pend`, the optional forwarding register and the port muxes.

## Test plan
- Reset, then requester 2 writes 0xDEADBEEF to address 0x010; next cycle requester 2 reads 0x010. Expect `gnt_o`=0b0100 both cycles, `rvalid_o`=0b0100 one cycle after the read grant, `rdata_o`=0xDEADBEEF.
- All 4 requesters read continuously from distinct addresses for 8 cycles after reset. Expect grants 0,1,2,3,0,1,2,3, each `rvalid_o` one cycle later with the matching data.
- Requester 0 writes and requester 1 reads in the same cycle to different addresses. Expect both granted in that cycle; the write is landed and the read returns the old contents of its address.
- Requester 0 writes 0x12345678 to 0x1FF while requester 3 reads 0x1FF in the same cycle, where the memory held 0x0:
  - With `RV32_DMEM_ARB_FWD_EN`: `rdata_o`=0x12345678.
  - Without it: `rdata_o`=0x0.
- Requester 1 is granted a read, and `rst_n` is asserted low in the following cycle. Expect `rvalid_o`=0 throughout and both pointers = 0 after release.
- Requesters 1 and 3 request reads continuously starting with the pointer at 2. Expect grant order 3,1,3,1 and no starvation.
